// File: rtl/rs3d_cand_engine_if.sv
// Probe/SAD handshake between the candidate engine (master) and the search-window/SAD path (slave).
interface rs3d_cand_engine_if #(
  parameter int MVW  = 7,
  parameter int SADW = 16
);
  logic [2*MVW-1:0] probe_mv;
  logic             probe_valid;
  logic             probe_ready;
  logic [SADW-1:0]  sad_in;
  logic             sad_valid;

  modport master (
    output probe_mv, probe_valid,
    input  probe_ready, sad_in, sad_valid
  );

  modport slave (
    input  probe_mv, probe_valid,
    output probe_ready, sad_in, sad_valid
  );
endinterface

// File: rtl/rs3d_cand_engine.sv
// 3DRS candidate evaluation engine: probes each valid candidate MV, keeps the lowest SAD+penalty.
// Optional RS3D_ZERO_CAND_EN: evaluate a zero vector with zero penalty ahead of candidate 0.
//
// state    | meaning
// S_IDLE   | waiting for i_start, candidates latched on acceptance
// S_SCAN   | priority search for the next unevaluated valid candidate
// S_ISSUE  | probe presented, held until the SAD path accepts it
// S_WAIT   | waiting for the SAD of the accepted probe
// S_FINISH | publish best vector/cost and pulse done
module rs3d_cand_engine #(
  parameter int NCAND = 4,
  parameter int MVW   = 7,
  parameter int SADW  = 16,
  parameter int PENW  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [NCAND*2*MVW-1:0]  i_cand_mv,
  input  logic [NCAND*PENW-1:0]   i_cand_pen,
  input  logic [NCAND-1:0]        i_cand_valid,
  rs3d_cand_engine_if.master      io_sad,
  output logic [2*MVW-1:0]        o_mv_out,
  output logic [SADW:0]           o_cost_out,
  output logic                    o_done,
  output logic                    o_busy
);

`ifdef RS3D_ZERO_CAND_EN
  localparam int NTOT = NCAND + 1;
`else
  localparam int NTOT = NCAND;
`endif
  localparam int IW = $clog2(NTOT + 1);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_FINISH} state_t;

  state_t                r_state;
  logic [NTOT*2*MVW-1:0] r_mv;
  logic [NTOT*PENW-1:0]  r_pen;
  logic [NTOT-1:0]       r_valid;
  logic [IW-1:0]         r_idx;
  logic [SADW:0]         r_best_cost;
  logic [2*MVW-1:0]      r_best_mv;
  logic [2*MVW-1:0]      r_probe_mv;
  logic                  r_probe_valid;
  logic [2*MVW-1:0]      r_mv_out;
  logic [SADW:0]         r_cost_out;
  logic                  r_done;
  logic                  r_busy;

  logic [NTOT*2*MVW-1:0] w_mv_ext;
  logic [NTOT*PENW-1:0]  w_pen_ext;
  logic [NTOT-1:0]       w_valid_ext;
  logic                  w_found;
  logic [IW-1:0]         w_next;
  logic [PENW-1:0]       w_pen;
  logic [SADW:0]         w_cost;

`ifdef RS3D_ZERO_CAND_EN
  assign w_mv_ext    = {i_cand_mv, {(2*MVW){1'b0}}};
  assign w_pen_ext   = {i_cand_pen, {PENW{1'b0}}};
  assign w_valid_ext = {i_cand_valid, 1'b1};
`else
  assign w_mv_ext    = i_cand_mv;
  assign w_pen_ext   = i_cand_pen;
  assign w_valid_ext = i_cand_valid;
`endif

  // Evaluated entries are cleared from r_valid, so the lowest set bit is the next candidate.
  always_comb begin
    w_found = 1'b0;
    w_next  = '0;
    for (int i = NTOT - 1; i >= 0; i--) begin
      if (r_valid[i]) begin
        w_found = 1'b1;
        w_next  = IW'(i);
      end
    end
  end

  assign w_pen  = r_pen[r_idx*PENW +: PENW];
  assign w_cost = {1'b0, io_sad.sad_in} + {{(SADW+1-PENW){1'b0}}, w_pen};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_mv          <= '0;
      r_pen         <= '0;
      r_valid       <= '0;
      r_idx         <= '0;
      r_best_cost   <= '0;
      r_best_mv     <= '0;
      r_probe_mv    <= '0;
      r_probe_valid <= 1'b0;
      r_mv_out      <= '0;
      r_cost_out    <= '0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mv        <= w_mv_ext;
            r_pen       <= w_pen_ext;
            r_valid     <= w_valid_ext;
            r_best_cost <= '1;
            r_best_mv   <= '0;
            r_idx       <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_found) begin
            r_idx           <= w_next;
            r_valid[w_next] <= 1'b0;
            r_probe_mv      <= r_mv[w_next*2*MVW +: 2*MVW];
            r_probe_valid   <= 1'b1;
            r_state         <= S_ISSUE;
          end else begin
            r_state <= S_FINISH;
          end
        end
        S_ISSUE: begin
          if (io_sad.probe_ready) begin
            r_probe_valid <= 1'b0;
            r_state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (io_sad.sad_valid) begin
            // Strict compare keeps the earliest candidate on ties.
            if (w_cost < r_best_cost) begin
              r_best_cost <= w_cost;
              r_best_mv   <= r_mv[r_idx*2*MVW +: 2*MVW];
            end
            r_idx   <= r_idx + 1'b1;
            r_state <= S_SCAN;
          end
        end
        S_FINISH: begin
          r_mv_out   <= r_best_mv;
          r_cost_out <= r_best_cost;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_sad.probe_mv    = r_probe_mv;
  assign io_sad.probe_valid = r_probe_valid;
  assign o_mv_out           = r_mv_out;
  assign o_cost_out         = r_cost_out;
  assign o_done             = r_done;
  assign o_busy             = r_busy;

endmodule

// File: tb/tb_rs3d_cand_engine.sv
// Directed, table-driven bench for rs3d_cand_engine (NCAND=4, MVW=7, SADW=16, PENW=8).
module tb_rs3d_cand_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [55:0] cand_mv;
  logic [31:0] cand_pen;
  logic [3:0]  cand_valid;
  logic [13:0] mv_out;
  logic [16:0] cost_out;
  logic        done;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  rs3d_cand_engine_if #(.MVW(7), .SADW(16)) sif ();

  rs3d_cand_engine #(.NCAND(4), .MVW(7), .SADW(16), .PENW(8)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_cand_mv    (cand_mv),
    .i_cand_pen   (cand_pen),
    .i_cand_valid (cand_valid),
    .io_sad       (sif.master),
    .o_mv_out     (mv_out),
    .o_cost_out   (cost_out),
    .o_done       (done),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]        valid;
    logic [3:0][13:0]  mv;
    logic [3:0][15:0]  sad;
    logic [3:0][7:0]   pen;
    logic [15:0]       zsad;
    logic [13:0]       exp_mv;
    logic [16:0]       exp_cost;
  } vec_t;

  localparam int NV = 8;
  vec_t tbl [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One block: start, serve every expected probe in order, then check the result.
  task automatic run_block(input vec_t v, input string tag);
    logic [13:0] q_mv[$];
    logic [15:0] q_sad[$];
    int w;
    q_mv.delete();
    q_sad.delete();
`ifdef RS3D_ZERO_CAND_EN
    q_mv.push_back(14'h0);
    q_sad.push_back(v.zsad);
`endif
    for (int i = 0; i < 4; i++) begin
      if (v.valid[i]) begin
        q_mv.push_back(v.mv[i]);
        q_sad.push_back(v.sad[i]);
      end
    end
    sif.probe_ready = 1'b1;
    cand_mv    = v.mv;
    cand_pen   = v.pen;
    cand_valid = v.valid;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);
    for (int j = 0; j < q_mv.size(); j++) begin
      w = 0;
      while (!sif.probe_valid && w < 20) begin
        tick();
        w++;
      end
      if (!sif.probe_valid) begin
        check({tag, " probe_timeout"}, 32'd0, 32'd1);
        return;
      end
      if (j == 0) check({tag, " first_probe_latency"}, 32'(w), 32'd1);
      check($sformatf("%s probe_mv[%0d]", tag, j), 32'(sif.probe_mv), 32'(q_mv[j]));
      tick();
      sif.sad_in    = q_sad[j];
      sif.sad_valid = 1'b1;
      tick();
      sif.sad_valid = 1'b0;
    end
    w = 0;
    while (!done && w < 20) begin
      tick();
      w++;
    end
    check({tag, " done_latency"}, 32'(w), 32'd2);
    check({tag, " mv_out"}, 32'(mv_out), 32'(v.exp_mv));
    check({tag, " cost_out"}, 32'(cost_out), 32'(v.exp_cost));
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    tick();
    check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    check({tag, " cost_hold"}, 32'(cost_out), 32'(v.exp_cost));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    reset         = 1'b1;
    start         = 1'b0;
    cand_mv       = '0;
    cand_pen      = '0;
    cand_valid    = '0;
    sif.probe_ready = 1'b1;
    sif.sad_in    = '0;
    sif.sad_valid = 1'b0;

    // Shared candidate vectors; columns are candidates 3..0.
    for (int t = 0; t < NV; t++) begin
      tbl[t].mv   = {14'h3F01, 14'h1234, 14'h0A7F, 14'h0105};
      tbl[t].pen  = '0;
      tbl[t].sad  = '0;
      tbl[t].zsad = '0;
    end
    tbl[0].valid = 4'b1111; tbl[0].sad = {16'd500, 16'd200, 16'd120, 16'd300};
    tbl[0].exp_mv = 14'h0A7F; tbl[0].exp_cost = 17'd120;
    tbl[1].valid = 4'b0011; tbl[1].sad = {16'd0, 16'd0, 16'd90, 16'd100}; tbl[1].pen = {8'd0, 8'd0, 8'd20, 8'd0};
    tbl[1].exp_mv = 14'h0105; tbl[1].exp_cost = 17'd100;
    tbl[2].valid = 4'b0011; tbl[2].sad = {16'd0, 16'd0, 16'd150, 16'd150};
    tbl[2].exp_mv = 14'h0105; tbl[2].exp_cost = 17'd150;
    tbl[3].valid = 4'b1010; tbl[3].sad = {16'd30, 16'd0, 16'd400, 16'd0}; tbl[3].pen = {8'd7, 8'd0, 8'd5, 8'd0};
    tbl[3].exp_mv = 14'h3F01; tbl[3].exp_cost = 17'd37;
    tbl[4].valid = 4'b0000;
    tbl[4].exp_mv = 14'h0; tbl[4].exp_cost = 17'h1FFFF;
    tbl[5].valid = 4'b1111; tbl[5].sad = {16'd40, 16'd60, 16'd40, 16'd50}; tbl[5].pen = {8'd0, 8'd0, 8'd10, 8'd0};
    tbl[5].exp_mv = 14'h3F01; tbl[5].exp_cost = 17'd40;
    tbl[6].valid = 4'b0100; tbl[6].sad = {16'd0, 16'hFFFF, 16'd0, 16'd0}; tbl[6].pen = {8'd0, 8'hFF, 8'd0, 8'd0};
    tbl[6].exp_mv = 14'h1234; tbl[6].exp_cost = 17'h100FE;
    tbl[7].valid = 4'b1001; tbl[7].sad = {16'd10, 16'd0, 16'd0, 16'd10}; tbl[7].pen = {8'd0, 8'd0, 8'd0, 8'd1};
    tbl[7].exp_mv = 14'h3F01; tbl[7].exp_cost = 17'd10;

    tick();
    tick();
    check("rst probe_valid", 32'(sif.probe_valid), 32'd0);
    check("rst probe_mv", 32'(sif.probe_mv), 32'd0);
    check("rst mv_out", 32'(mv_out), 32'd0);
    check("rst cost_out", 32'(cost_out), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

`ifndef RS3D_ZERO_CAND_EN
    for (int t = 0; t < NV; t++) run_block(tbl[t], $sformatf("v%0d", t));

    // Backpressure, spurious sad_valid and a second start while busy.
    cand_mv    = {14'h0, 14'h0, 14'h0, 14'h2A55};
    cand_pen   = {8'd0, 8'd0, 8'd0, 8'd3};
    cand_valid = 4'b0001;
    sif.probe_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("bp probe_valid_initial", 32'(sif.probe_valid), 32'd1);
    check("bp probe_mv_initial", 32'(sif.probe_mv), 32'h2A55);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        sif.sad_in    = 16'd0;
        sif.sad_valid = 1'b1;
      end
      if (i == 2) begin
        cand_mv    = {14'h1111, 14'h2222, 14'h3333, 14'h0001};
        cand_pen   = '0;
        cand_valid = 4'b1111;
        start      = 1'b1;
      end
      tick();
      sif.sad_valid = 1'b0;
      start         = 1'b0;
      check($sformatf("bp probe_valid[%0d]", i), 32'(sif.probe_valid), 32'd1);
      check($sformatf("bp probe_mv[%0d]", i), 32'(sif.probe_mv), 32'h2A55);
      check($sformatf("bp busy[%0d]", i), 32'(busy), 32'd1);
    end
    sif.probe_ready = 1'b1;
    tick();
    check("bp probe_dropped", 32'(sif.probe_valid), 32'd0);
    sif.sad_in    = 16'd77;
    sif.sad_valid = 1'b1;
    tick();
    sif.sad_valid = 1'b0;
    tick();
    tick();
    check("bp done", 32'(done), 32'd1);
    check("bp mv_out", 32'(mv_out), 32'h2A55);
    check("bp cost_out", 32'(cost_out), 32'd80);
    tick();
    check("bp no_second_block", 32'(busy), 32'd0);
    v = tbl[0];
`else
    v.valid = 4'b0011;
    v.mv    = {14'h0, 14'h0, 14'h0A7F, 14'h0105};
    v.sad   = {16'd0, 16'd0, 16'd60, 16'd80};
    v.pen   = {8'd0, 8'd0, 8'd30, 8'd0};
    v.zsad  = 16'd80;
    v.exp_mv = 14'h0; v.exp_cost = 17'd80;
    run_block(v, "zc_tie");
    v.valid = 4'b0000; v.zsad = 16'd55; v.exp_cost = 17'd55;
    run_block(v, "zc_none");
    v.valid = 4'b0011; v.zsad = 16'd200; v.exp_mv = 14'h0105; v.exp_cost = 17'd80;
    run_block(v, "zc_lose");
`endif

    // Reset while waiting for a SAD, then a clean block.
    sif.probe_ready = 1'b1;
    cand_mv    = v.mv;
    cand_pen   = v.pen;
    cand_valid = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("rw in_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw probe_valid", 32'(sif.probe_valid), 32'd0);
    check("rw probe_mv", 32'(sif.probe_mv), 32'd0);
    check("rw mv_out", 32'(mv_out), 32'd0);
    check("rw cost_out", 32'(cost_out), 32'd0);
    check("rw done", 32'(done), 32'd0);
    check("rw busy", 32'(busy), 32'd0);
    tick();
    run_block(v, "post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
